// File: rtl/adder_result_buffer_pkg.sv
// Shared width helpers for the adder result buffer and its FIFO.
package adder_result_buffer_pkg;

    function automatic int result_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; reads return zero while empty.
module sync_fifo
    import adder_result_buffer_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [clog2(DEPTH):0] count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             not_empty;
    logic             pop;

    assign not_empty = (count != '0);
    assign pop       = rd_en & not_empty;
    assign rd_data   = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/adder_result_buffer.sv
// Captures {c, sum} from a fixed-latency adder and buffers it behind a
// valid/ready interface; upstream acceptance is credit-limited to FIFO space.
module adder_result_buffer
    import adder_result_buffer_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              sum,
    input  logic                           c,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [result_width(DATA_W)-1:0] out_data,
    output logic [clog2(DEPTH):0]          level
);

    localparam int RES_W = result_width(DATA_W);
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic [LATENCY-1:0] vld_p;
    logic [LVL_W-1:0]   credits;
    logic               fire;
    logic               pop;
    logic               wr_en;
    logic [RES_W-1:0]   wr_data;

    assign in_ready  = (credits != '0);
    assign fire      = in_valid & in_ready;
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = vld_p[LATENCY-1];
    assign wr_data   = {c, sum};

    // Valid delay line: stage k marks operands that entered the adder k+1 cycles ago.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= fire;
            for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // Credits reserve a FIFO slot for every operand pair still in the adder.
    always_ff @(posedge CLK) begin
        if (RST) begin
            credits <= LVL_W'(DEPTH);
        end else begin
            case ({fire, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) assert (!(wr_en && (level == LVL_W'(DEPTH))));
    end

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .count   (level)
    );

endmodule

// File: tb/tb_adder_result_buffer.sv
// Randomized scoreboard bench for adder_result_buffer with a behavioural adder model.
module tb_adder_result_buffer;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       c;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic [2:0] level;

    typedef struct {
        logic [4:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] hist[$];
    int         cyc     = 0;
    bit         started = 0;
    int         passed  = 0;
    int         total   = 0;

    adder_result_buffer #(
        .DATA_W  (4),
        .LATENCY (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s (cycle %0d): actual %0d required %0d", name, cyc, act, req);
    endtask

    // One cycle of stimulus. The adder model returns a+b of the operands
    // presented LAT cycles earlier; force_out pins the adder output to 5'h1F.
    task automatic step(input logic rst, input logic iv, input logic ordy,
                        input logic [3:0] a, input logic [3:0] b, input logic force_out);
        logic [4:0] res;
        @(posedge CLK);
        #1;
        cyc++;
        started   = 1'b1;
        RST       = rst;
        in_valid  = iv;
        out_ready = ordy;
        res       = {1'b0, a} + {1'b0, b};
        hist.push_back(res);
        if (hist.size() > 8) void'(hist.pop_front());
        if (force_out)            {c, sum} = 5'h1F;
        else if (hist.size() > LAT) {c, sum} = hist[hist.size() - 1 - LAT];
        else                      {c, sum} = 5'($urandom);
        if (rst) sb.delete();
        else if (iv && sb.size() < DEPTH) sb.push_back('{data: res, cyc: cyc});
    endtask

    // Monitor: mid-cycle comparison of the DUT against the scoreboard timing model.
    always @(negedge CLK) begin
        int  pre;
        int  ready_cnt;
        bit  exp_valid;
        if (started && !RST) begin
            pre       = 0;
            ready_cnt = 0;
            foreach (sb[i]) begin
                if (sb[i].cyc < cyc) pre++;
                if (sb[i].cyc + LAT + 1 <= cyc) ready_cnt++;
            end
            exp_valid = (ready_cnt != 0);
            check("in_ready", int'(in_ready), int'(pre < DEPTH));
            check("out_valid", int'(out_valid), int'(exp_valid));
            check("level", int'(level), ready_cnt);
            if (exp_valid) begin
                check("out_data", int'(out_data), int'(sb[0].data));
                if (out_ready) void'(sb.pop_front());
            end else begin
                check("out_data_idle", int'(out_data), 0);
            end
        end
    end

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        c         = 1'b0;

        // Reset with a constant 1_1111 on the adder outputs, never captured.
        repeat (2) step(1'b1, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1);

        // Single operation 9 + 8.
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h8, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);

        // Back-pressure until full, then pop and fire together.
        for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, 1'b0, 4'(k), 4'(k), 1'b0);
        for (int k = 11; k <= 18; k++) step(1'b0, 1'b1, 1'b1, 4'(k), 4'(k), 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);

        // Full-rate streaming.
        repeat (20) step(1'b0, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);

        // Reset with three operands in flight.
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b0);

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);

        @(posedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
